// File: rtl/tone_generator.sv
// Square-wave tone generator: latches a do..ti note code and octave, divides clk to the pitch.
// Optional release sustain compiled in with `define TONE_SUSTAIN_EN.
module tone_generator #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int SUSTAIN_CYCLES = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] note_in,
  input  logic [1:0] octave,
  output logic       tone_out,
  output logic       playing,
  output logic [3:0] cur_note
);

  function automatic int half_period(input real f);
    return $rtoi(real'(CLK_FREQ) / (2.0 * f) + 0.5);
  endfunction

  localparam int H_DO = half_period(261.63);
  localparam int H_RE = half_period(293.66);
  localparam int H_MI = half_period(329.63);
  localparam int H_FA = half_period(349.23);
  localparam int H_SO = half_period(392.00);
  localparam int H_LA = half_period(440.00);
  localparam int H_TI = half_period(493.88);

  // Low-octave do is the longest half-period the counter must reach.
  localparam int CW = ($clog2(2 * H_DO + 1) > 19) ? $clog2(2 * H_DO + 1) : 19;

  typedef enum logic [1:0] {
    IDLE,
    PLAY
`ifdef TONE_SUSTAIN_EN
    , SUSTAIN
`endif
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] hp, hp_n;
  logic [CW-1:0] base_hp, new_hp;
  logic          tone_n, play_n;
  logic [3:0]    note_n;
  logic          note_ok, latch, run, idle;

`ifdef TONE_SUSTAIN_EN
  localparam int SW = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;
  localparam logic [SW-1:0] SUS_LAST = SW'(SUSTAIN_CYCLES - 1);
  logic [SW-1:0] sus_cnt, sus_n;
`endif

  assign note_ok = (note_in != 4'd0) && (note_in < 4'd8);

  always_comb begin
    case (note_in)
      4'd1:    base_hp = CW'(H_DO);
      4'd2:    base_hp = CW'(H_RE);
      4'd3:    base_hp = CW'(H_MI);
      4'd4:    base_hp = CW'(H_FA);
      4'd5:    base_hp = CW'(H_SO);
      4'd6:    base_hp = CW'(H_LA);
      4'd7:    base_hp = CW'(H_TI);
      default: base_hp = '0;
    endcase
    case (octave)
      2'd0:    new_hp = base_hp << 1;
      2'd2:    new_hp = base_hp >> 1;
      default: new_hp = base_hp;
    endcase
  end

  // Each state only picks an action; latch/run/idle then build the next register values.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hp_n    = hp;
    tone_n  = tone_out;
    play_n  = playing;
    note_n  = cur_note;
    latch   = 1'b0;
    run     = 1'b0;
    idle    = 1'b0;
`ifdef TONE_SUSTAIN_EN
    sus_n   = sus_cnt;
`endif
    case (state)
      IDLE: latch = note_ok;
      PLAY: begin
        if (!note_ok) begin
`ifdef TONE_SUSTAIN_EN
          state_n = SUSTAIN;
          sus_n   = '0;
          run     = 1'b1;
`else
          idle    = 1'b1;
`endif
        end else if (note_in != cur_note) begin
          latch = 1'b1;
        end else begin
          run = 1'b1;
        end
      end
`ifdef TONE_SUSTAIN_EN
      SUSTAIN: begin
        if (note_ok) begin
          latch = 1'b1;
          sus_n = '0;
        end else if (sus_cnt == SUS_LAST) begin
          idle = 1'b1;
        end else begin
          sus_n = sus_cnt + 1'b1;
          run   = 1'b1;
        end
      end
`endif
      default: idle = 1'b1;
    endcase

    // Re-latch keeps tone_out at its level so a note change adds no extra edge.
    if (latch) begin
      state_n = PLAY;
      note_n  = note_in;
      hp_n    = new_hp;
      cnt_n   = '0;
      play_n  = 1'b1;
    end
    if (run) begin
      if (cnt == hp - 1'b1) begin
        cnt_n  = '0;
        tone_n = ~tone_out;
      end else begin
        cnt_n  = cnt + 1'b1;
      end
    end
    if (idle) begin
      state_n = IDLE;
      cnt_n   = '0;
      hp_n    = '0;
      tone_n  = 1'b0;
      play_n  = 1'b0;
      note_n  = 4'd0;
`ifdef TONE_SUSTAIN_EN
      sus_n   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      hp       <= '0;
      tone_out <= 1'b0;
      playing  <= 1'b0;
      cur_note <= 4'd0;
`ifdef TONE_SUSTAIN_EN
      sus_cnt  <= '0;
`endif
    end else begin
      cnt      <= cnt_n;
      hp       <= hp_n;
      tone_out <= tone_n;
      playing  <= play_n;
      cur_note <= note_n;
`ifdef TONE_SUSTAIN_EN
      sus_cnt  <= sus_n;
`endif
    end
  end

endmodule

// File: tb/tb_tone_generator.sv
// Bench for tone_generator at CLK_FREQ = 1 MHz: vector table plus hand-written note/reset/sustain sequences.
// Half-periods at 1 MHz: do 1911, re 1703, mi 1517, fa 1432, so 1276, la 1136, ti 1012.
module tb_tone_generator;
  localparam int CLK_FREQ = 1_000_000;
  localparam int SUS      = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] note_in;
  logic [1:0] octave;
  logic       tone_out;
  logic       playing;
  logic [3:0] cur_note;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    logic [3:0] note;
    logic [1:0] oct;
    int         hp;   // 0: invalid code, block must stay silent
  } vec_t;
  vec_t vecs[10];

  tone_generator #(.CLK_FREQ(CLK_FREQ), .SUSTAIN_CYCLES(SUS)) dut (
    .clk(clk), .rst(rst), .note_in(note_in), .octave(octave),
    .tone_out(tone_out), .playing(playing), .cur_note(cur_note)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int t, input int p, input int n);
    check({name, ".tone_out"}, int'(tone_out), t);
    check({name, ".playing"},  int'(playing),  p);
    check({name, ".cur_note"}, int'(cur_note), n);
  endtask

  // Clocks until tone_out changes, counted from the current (post-edge) sample; -1 on timeout.
  task automatic measure(output int n);
    logic prev;
    prev = tone_out;
    n = -1;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk);
      if (tone_out !== prev) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic expect_next(input string name);
    int n, e;
    measure(n);
    if (exp_q.size() == 0) begin
      check({name, ".queue_empty"}, n, -2);
    end else begin
      e = exp_q.pop_front();
      check(name, n, e);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{4'd6, 2'd1, 1136};
    vecs[1] = '{4'd1, 2'd0, 3822};
    vecs[2] = '{4'd1, 2'd2, 955};
    vecs[3] = '{4'd9, 2'd1, 0};
    vecs[4] = '{4'd5, 2'd1, 1276};
    vecs[5] = '{4'd3, 2'd1, 1517};
    vecs[6] = '{4'd2, 2'd3, 1703};
    vecs[7] = '{4'd7, 2'd2, 506};
    vecs[8] = '{4'd0, 2'd1, 0};
    vecs[9] = '{4'd4, 2'd0, 2864};

    rst = 1'b1; note_in = 4'd0; octave = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_out("reset", 0, 0, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_out("idle", 0, 0, 0);

    for (int v = 0; v < 10; v++) begin
      note_in = vecs[v].note;
      octave  = vecs[v].oct;
      if (vecs[v].hp == 0) begin
        repeat (3) @(negedge clk);
        check_out("invalid_note", 0, 0, 0);
        note_in = 4'd0;
        continue;
      end
      repeat (3) exp_q.push_back(vecs[v].hp);
      @(negedge clk);
      check_out("latch", 0, 1, int'(vecs[v].note));
      repeat (3) expect_next("half_period");
      check("tone_high_before_release", int'(tone_out), 1);
`ifndef TONE_SUSTAIN_EN
      note_in = 4'd0;
      @(negedge clk);
      check_out("release", 0, 0, 0);
`else
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_out("reset_clear", 0, 0, 0);
`endif
    end

    // Switch 5 -> 3 mid half-period: level held, next toggle a full mi half-period later.
    note_in = 4'd5; octave = 2'd1;
    exp_q.push_back(1276);
    @(negedge clk);
    expect_next("so_first");
    repeat (600) @(negedge clk);
    note_in = 4'd3;
    exp_q.push_back(1517);
    @(negedge clk);
    check_out("switch", 1, 1, 3);
    expect_next("switch_interval");

    // Same note held: octave change ignored; a new note picks the new octave up.
    octave = 2'd2;
    exp_q.push_back(1517);
    expect_next("octave_ignored");
    note_in = 4'd1;
    exp_q.push_back(955);
    @(negedge clk);
    check("relatch_note", int'(cur_note), 1);
    expect_next("relatch_octave");

    // Reset mid-tone with a valid note held; play resumes one edge after release of reset.
    note_in = 4'd4; octave = 2'd1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_out("rst_mid_tone", 0, 0, 0);
    @(negedge clk);
    check_out("rst_held", 0, 0, 0);
    rst = 1'b0;
    exp_q.push_back(1432);
    @(negedge clk);
    check_out("resume", 0, 1, 4);
    expect_next("resume_interval");

`ifdef TONE_SUSTAIN_EN
    note_in = 4'd0;
    @(negedge clk);
    check("sustain_entry", int'(playing), 1);
    n = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (!playing) begin
        n = i;
        break;
      end
    end
    check("sustain_len", n, SUS);
    check_out("sustain_end", 0, 0, 0);

    note_in = 4'd5;
    @(negedge clk);
    note_in = 4'd0;
    @(negedge clk);
    repeat (499) @(negedge clk);
    note_in = 4'd2;
    @(negedge clk);
    check("sustain_interrupt.playing", int'(playing), 1);
    check("sustain_interrupt.cur_note", int'(cur_note), 2);

    note_in = 4'd0;
    repeat (10) @(negedge clk);
    note_in = 4'd4;
    rst = 1'b1;
    @(negedge clk);
    check_out("rst_mid_sustain", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check_out("resume_after_sustain", 0, 1, 4);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
